collision_ctrl: RTL and testbench

COLLISION_CTRL -- requirements
Module: collision_ctrl

---
 rtl/collision_ctrl.sv | 177 +++++++++++++++++
 tb/tb_collision_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/collision_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : collision_ctrl                                           |
// | Brief   : Per-frame collision latching, object resets, score and   |
// |           lives bookkeeping for a raster-scanned arcade game.      |
// | Option  : define SHIP_COLLIDE_EN to enable ship-rock collisions.   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module collision_ctrl #(
  parameter int NUM_BULLETS = 4,
  parameter int NUM_ROCKS   = 10,
  parameter int LIVES_INIT  = 3
) (
  input  logic                           iCLK,
  input  logic                           iRST,
  input  logic [9:0]                     iPX,
  input  logic [9:0]                     iPY,
  input  logic                           iFrameTick,
  input  logic                           iRestart,
  input  logic                           iShipPix,
  input  logic [NUM_BULLETS-1:0]         iBulletPix,
  input  logic [NUM_ROCKS-1:0]           iRockPix,
  output logic [NUM_BULLETS+NUM_ROCKS:0] oObjReset,
  output logic [15:0]                    oScore,
  output logic [2:0]                     oLives,
  output logic                           oGameOver
);

  localparam int OBJ_W = 1 + NUM_BULLETS + NUM_ROCKS;

  localparam logic [1:0] HOLD  = 2'd0;
  localparam logic [1:0] SCAN  = 2'd1;
  localparam logic [1:0] APPLY = 2'd2;
  localparam logic [1:0] OVER  = 2'd3;

  localparam logic [2:0] LIVES_RST = 3'(LIVES_INIT);

  function automatic logic [16:0] popcount(input logic [NUM_ROCKS-1:0] v);
    logic [16:0] n;
    n = '0;
    for (int i = 0; i < NUM_ROCKS; i++) begin
      n = n + 17'(v[i]);
    end
    return n;
  endfunction

  logic [1:0]             state;
  logic                   ship_hit;
  logic [NUM_BULLETS-1:0] hit_b;
  logic [NUM_ROCKS-1:0]   hit_r_bullet;
  logic [NUM_ROCKS-1:0]   hit_r_ship;

  // Objects currently held in reset cannot take part in a collision.
  logic                   visible;
  logic                   ship_live;
  logic [NUM_BULLETS-1:0] bullet_live;
  logic [NUM_ROCKS-1:0]   rock_live;
  logic                   any_bullet;
  logic                   any_rock;

  assign visible     = (iPX < 10'd640) && (iPY < 10'd480);
  assign ship_live   = iShipPix & ~oObjReset[0];
  assign bullet_live = iBulletPix & ~oObjReset[NUM_BULLETS:1];
  assign rock_live   = iRockPix & ~oObjReset[OBJ_W-1:NUM_BULLETS+1];
  assign any_bullet  = |bullet_live;
  assign any_rock    = |rock_live;

  logic                   det_ship;
  logic [NUM_BULLETS-1:0] det_b;
  logic [NUM_ROCKS-1:0]   det_r_bullet;
  logic [NUM_ROCKS-1:0]   det_r_ship;

  assign det_b        = (visible && any_rock)   ? bullet_live : '0;
  assign det_r_bullet = (visible && any_bullet) ? rock_live   : '0;

`ifdef SHIP_COLLIDE_EN
  assign det_ship   = visible & ship_live & any_rock;
  assign det_r_ship = det_ship ? rock_live : '0;
`else
  logic unused_ship;
  assign unused_ship = ship_live;
  assign det_ship    = 1'b0;
  assign det_r_ship  = '0;
`endif

  // Values presented to the APPLY cycle.
  logic [NUM_ROCKS-1:0] hit_r;
  logic [16:0]          score_sum;
  logic [15:0]          score_next;
  logic [2:0]           lives_next;
  logic                 any_reset;

  assign hit_r      = hit_r_bullet | hit_r_ship;
  assign score_sum  = {1'b0, oScore} + popcount(hit_r_bullet);
  assign score_next = score_sum[16] ? 16'hFFFF : score_sum[15:0];
  assign lives_next = (ship_hit && (oLives != 3'd0)) ? (oLives - 3'd1) : oLives;
  assign any_reset  = ship_hit | (|hit_b) | (|hit_r);

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state        <= HOLD;
      oObjReset    <= '1;
      oScore       <= 16'd0;
      oLives       <= LIVES_RST;
      oGameOver    <= 1'b0;
      ship_hit     <= 1'b0;
      hit_b        <= '0;
      hit_r_bullet <= '0;
      hit_r_ship   <= '0;
    end else begin
      case (state)
        SCAN: begin
          ship_hit     <= ship_hit | det_ship;
          hit_b        <= hit_b | det_b;
          hit_r_bullet <= hit_r_bullet | det_r_bullet;
          hit_r_ship   <= hit_r_ship | det_r_ship;
          if (iFrameTick) begin
            state <= APPLY;
          end
        end

        APPLY: begin
          oObjReset    <= {hit_r, hit_b, ship_hit};
          oScore       <= score_next;
          oLives       <= lives_next;
          ship_hit     <= 1'b0;
          hit_b        <= '0;
          hit_r_bullet <= '0;
          hit_r_ship   <= '0;
          if (lives_next == 3'd0) begin
            state     <= OVER;
            oObjReset <= '1;
            oGameOver <= 1'b1;
          end else if (any_reset) begin
            state <= HOLD;
          end else begin
            state <= SCAN;
          end
        end

        HOLD: begin
          // Masked detection keeps already-reset objects out of the latches.
          ship_hit     <= ship_hit | det_ship;
          hit_b        <= hit_b | det_b;
          hit_r_bullet <= hit_r_bullet | det_r_bullet;
          hit_r_ship   <= hit_r_ship | det_r_ship;
          if (iFrameTick) begin
            oObjReset <= '0;
            state     <= SCAN;
          end
        end

        OVER: begin
          oObjReset    <= '1;
          oGameOver    <= 1'b1;
          ship_hit     <= 1'b0;
          hit_b        <= '0;
          hit_r_bullet <= '0;
          hit_r_ship   <= '0;
          if (iRestart) begin
            oLives    <= LIVES_RST;
            oScore    <= 16'd0;
            oGameOver <= 1'b0;
            state     <= HOLD;
          end
        end

        default: begin
          state     <= HOLD;
          oObjReset <= '1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_collision_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : tb_collision_ctrl                                        |
// | Brief   : Directed vector bench for collision_ctrl.                |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_collision_ctrl;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b1;
  logic [9:0]  iPX = '0;
  logic [9:0]  iPY = '0;
  logic        iFrameTick = 1'b0;
  logic        iRestart = 1'b0;
  logic        iShipPix = 1'b0;
  logic [3:0]  iBulletPix = '0;
  logic [9:0]  iRockPix = '0;
  logic [14:0] oObjReset;
  logic [15:0] oScore;
  logic [2:0]  oLives;
  logic        oGameOver;

  int errors = 0;
  int checks = 0;

  collision_ctrl #(
    .NUM_BULLETS(4),
    .NUM_ROCKS  (10),
    .LIVES_INIT (3)
  ) dut (
    .iCLK      (iCLK),
    .iRST      (iRST),
    .iPX       (iPX),
    .iPY       (iPY),
    .iFrameTick(iFrameTick),
    .iRestart  (iRestart),
    .iShipPix  (iShipPix),
    .iBulletPix(iBulletPix),
    .iRockPix  (iRockPix),
    .oObjReset (oObjReset),
    .oScore    (oScore),
    .oLives    (oLives),
    .oGameOver (oGameOver)
  );

  always #5 iCLK = ~iCLK;

  typedef struct {
    logic [9:0]  px;
    logic [9:0]  py;
    logic        tick;
    logic [3:0]  bul;
    logic [9:0]  rock;
    logic [14:0] exp_obj;
    logic [15:0] exp_score;
  } vec_t;

  vec_t vecs[22];

  function automatic vec_t mk(input logic [9:0] px, input logic [9:0] py, input logic tick,
                              input logic [3:0] bul, input logic [9:0] rock,
                              input logic [14:0] obj, input logic [15:0] score);
    vec_t v;
    v.px = px; v.py = py; v.tick = tick; v.bul = bul; v.rock = rock;
    v.exp_obj = obj; v.exp_score = score;
    return v;
  endfunction

  // Inputs change 1 time unit after the edge; outputs are sampled at the same point.
  task automatic drive(input logic [9:0] px, input logic [9:0] py, input logic tick,
                       input logic restart, input logic ship,
                       input logic [3:0] bul, input logic [9:0] rock);
    iPX = px; iPY = py; iFrameTick = tick; iRestart = restart;
    iShipPix = ship; iBulletPix = bul; iRockPix = rock;
    @(posedge iCLK);
    #1;
  endtask

  task automatic idle();
    drive(10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 4'd0, 10'd0);
  endtask

  task automatic tick_only();
    drive(10'd0, 10'd0, 1'b1, 1'b0, 1'b0, 4'd0, 10'd0);
  endtask

  task automatic frame(input logic [3:0] bul, input logic [9:0] rock);
    drive(10'd100, 10'd50, 1'b1, 1'b0, 1'b0, bul, rock);
    idle();
    tick_only();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [14:0] obj, input logic [15:0] sc,
                         input logic [2:0] lv, input logic go);
    chk({tag, " obj"},   32'(oObjReset), 32'(obj));
    chk({tag, " score"}, 32'(oScore),    32'(sc));
    chk({tag, " lives"}, 32'(oLives),    32'(lv));
    chk({tag, " over"},  32'(oGameOver), 32'(go));
  endtask

  initial begin
    vecs[0]  = mk(10'd0,   10'd0,   1'b0, 4'b0000, 10'b0000000000, 15'h7FFF, 16'd0);
    vecs[1]  = mk(10'd0,   10'd0,   1'b1, 4'b0000, 10'b0000000000, 15'h0000, 16'd0);
    vecs[2]  = mk(10'd100, 10'd50,  1'b0, 4'b0010, 10'b0000000100, 15'h0000, 16'd0);
    vecs[3]  = mk(10'd0,   10'd0,   1'b1, 4'b0000, 10'b0000000000, 15'h0000, 16'd0);
    vecs[4]  = mk(10'd0,   10'd0,   1'b0, 4'b0000, 10'b0000000000, 15'h0084, 16'd1);
    vecs[5]  = mk(10'd100, 10'd50,  1'b0, 4'b0001, 10'b0000000001, 15'h0084, 16'd1);
    vecs[6]  = mk(10'd100, 10'd50,  1'b0, 4'b0010, 10'b0000000100, 15'h0084, 16'd1);
    vecs[7]  = mk(10'd0,   10'd0,   1'b1, 4'b0000, 10'b0000000000, 15'h0000, 16'd1);
    vecs[8]  = mk(10'd0,   10'd0,   1'b1, 4'b0000, 10'b0000000000, 15'h0000, 16'd1);
    vecs[9]  = mk(10'd0,   10'd0,   1'b0, 4'b0000, 10'b0000000000, 15'h0022, 16'd2);
    vecs[10] = mk(10'd0,   10'd0,   1'b1, 4'b0000, 10'b0000000000, 15'h0000, 16'd2);
    vecs[11] = mk(10'd700, 10'd50,  1'b0, 4'b0001, 10'b0000000001, 15'h0000, 16'd2);
    vecs[12] = mk(10'd100, 10'd480, 1'b0, 4'b0001, 10'b0000000001, 15'h0000, 16'd2);
    vecs[13] = mk(10'd640, 10'd0,   1'b0, 4'b0001, 10'b0000000001, 15'h0000, 16'd2);
    vecs[14] = mk(10'd0,   10'd0,   1'b1, 4'b0000, 10'b0000000000, 15'h0000, 16'd2);
    vecs[15] = mk(10'd0,   10'd0,   1'b0, 4'b0000, 10'b0000000000, 15'h0000, 16'd2);
    vecs[16] = mk(10'd639, 10'd479, 1'b1, 4'b0001, 10'b1000000000, 15'h0000, 16'd2);
    vecs[17] = mk(10'd0,   10'd0,   1'b0, 4'b0000, 10'b0000000000, 15'h4002, 16'd3);
    vecs[18] = mk(10'd100, 10'd50,  1'b0, 4'b0011, 10'b1000000000, 15'h4002, 16'd3);
    vecs[19] = mk(10'd0,   10'd0,   1'b1, 4'b0000, 10'b0000000000, 15'h0000, 16'd3);
    vecs[20] = mk(10'd0,   10'd0,   1'b1, 4'b0000, 10'b0000000000, 15'h0000, 16'd3);
    vecs[21] = mk(10'd0,   10'd0,   1'b0, 4'b0000, 10'b0000000000, 15'h0000, 16'd3);

    iRST = 1'b1;
    idle();
    idle();
    chk_all("reset", 15'h7FFF, 16'd0, 3'd3, 1'b0);
    iRST = 1'b0;

    for (int i = 0; i < 22; i++) begin
      drive(vecs[i].px, vecs[i].py, vecs[i].tick, 1'b0, 1'b0, vecs[i].bul, vecs[i].rock);
      chk($sformatf("vec%0d obj", i),   32'(oObjReset), 32'(vecs[i].exp_obj));
      chk($sformatf("vec%0d score", i), 32'(oScore),    32'(vecs[i].exp_score));
      chk($sformatf("vec%0d lives", i), 32'(oLives),    32'd3);
    end

`ifdef SHIP_COLLIDE_EN
    for (int f = 0; f < 2; f++) begin
      drive(10'd10, 10'd10, 1'b1, 1'b0, 1'b1, 4'd0, 10'b0000000001);
      idle();
      chk_all($sformatf("ship frame%0d", f), 15'h0021, 16'd3, 3'(2 - f), 1'b0);
      tick_only();
    end
    drive(10'd10, 10'd10, 1'b1, 1'b0, 1'b1, 4'd0, 10'b0000000001);
    idle();
    chk_all("last life", 15'h7FFF, 16'd3, 3'd0, 1'b1);
    drive(10'd10, 10'd10, 1'b1, 1'b0, 1'b1, 4'd0, 10'b0000000001);
    chk_all("over hold", 15'h7FFF, 16'd3, 3'd0, 1'b1);
    drive(10'd0, 10'd0, 1'b0, 1'b1, 1'b0, 4'd0, 10'd0);
    chk_all("restart", 15'h7FFF, 16'd0, 3'd3, 1'b0);
    tick_only();
    chk("restart scan obj", 32'(oObjReset), 32'h0);
    drive(10'd100, 10'd50, 1'b1, 1'b0, 1'b1, 4'b0001, 10'b0000000001);
    idle();
    chk_all("ship+bullet+rock", 15'h0023, 16'd1, 3'd2, 1'b0);
    tick_only();
`else
    drive(10'd10, 10'd10, 1'b1, 1'b0, 1'b1, 4'd0, 10'b0000000001);
    idle();
    chk_all("ship ignored", 15'h0000, 16'd3, 3'd3, 1'b0);
`endif

    // Reset asserted while the APPLY cycle is in progress.
    drive(10'd100, 10'd50, 1'b1, 1'b0, 1'b0, 4'b0001, 10'b0000000001);
    iRST = 1'b1;
    idle();
    chk_all("rst in apply", 15'h7FFF, 16'd0, 3'd3, 1'b0);
    iRST = 1'b0;
    idle();
    chk("post rst hold obj", 32'(oObjReset), 32'h7FFF);
    tick_only();
    tick_only();
    idle();
    chk_all("post rst frame", 15'h0000, 16'd0, 3'd3, 1'b0);

    // Score saturation: 6553 frames of ten rocks plus one of four lands on FFFE.
    for (int f = 0; f < 6553; f++) begin
      frame(4'b0001, 10'h3FF);
    end
    frame(4'b0001, 10'h00F);
    chk("score FFFE", 32'(oScore), 32'hFFFE);
    drive(10'd100, 10'd50, 1'b1, 1'b0, 1'b0, 4'b0011, 10'b0000000011);
    idle();
    chk("sat obj", 32'(oObjReset), 32'h0066);
    chk("score FFFF", 32'(oScore), 32'hFFFF);
    tick_only();
    drive(10'd100, 10'd50, 1'b1, 1'b0, 1'b0, 4'b0001, 10'h3FF);
    idle();
    chk("score held FFFF", 32'(oScore), 32'hFFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
